// File: rtl/sw_sweep_ctrl.sv
// Sweeps the 4-bit switch code of the lab 4 unit through 0..15. Each code is
// settled, captured into a 16-entry log and compared with the expected masks.
module sw_sweep_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXP_LED0 = 16'h0000,
  parameter logic [15:0] EXP_LED1 = 16'h0000,
  parameter logic [15:0] EXP_SEGA = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mode,
  input  logic       step_btn,
  input  logic       dut_led0,
  input  logic       dut_led1,
  input  logic       dut_seg_a,
  output logic [3:0] sw_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_WAIT, S_DONE} state_t;

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t           state;
  logic [3:0]       code;
  logic [SW-1:0]    settle_cnt;
  logic [PW-1:0]    presc;
  logic             prev_btn;
  logic [15:0][2:0] log_q;

  logic [2:0] cap, exp_bits;
  logic       mism, btn_rise, step_go;

  assign cap      = {dut_seg_a, dut_led1, dut_led0};
  assign exp_bits = {EXP_SEGA[code], EXP_LED1[code], EXP_LED0[code]};
  assign mism     = (cap != exp_bits);
  assign btn_rise = step_btn & ~prev_btn;
  // prescaler saturates, so switching manual->auto late in a dwell steps at once
  assign step_go  = mode ? btn_rise : (presc == PRESC_MAX);
  assign rd_data  = log_q[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      code       <= '0;
      settle_cnt <= '0;
      presc      <= '0;
      prev_btn   <= 1'b0;
      log_q      <= '0;
      sw_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prev_btn <= step_btn;
      if (abort) begin
        state  <= S_IDLE;
        sw_out <= '0;
        busy   <= 1'b0;
        done   <= 1'b0;
        pass   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state      <= S_SETTLE;
              code       <= '0;
              sw_out     <= '0;
              err_cnt    <= '0;
              settle_cnt <= SETTLE_LD;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == SW'(1)) state <= S_CAPTURE;
            else settle_cnt <= settle_cnt - SW'(1);
          end
          S_CAPTURE: begin
            log_q[code] <= cap;
            if (mism) err_cnt <= err_cnt + 5'd1;
            presc <= '0;
            if (code == 4'd15) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt == 5'd0) && !mism;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (presc != PRESC_MAX) presc <= presc + PW'(1);
            if (step_go) begin
              code       <= code + 4'd1;
              sw_out     <= code + 4'd1;
              settle_cnt <= SETTLE_LD;
              state      <= S_SETTLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sw_sweep_ctrl.sv
// Randomized bench for sw_sweep_ctrl: a modelled unit with injectable faults
// feeds the sequencer; expected logs and error counts come from the truth tables.
module tb_sw_sweep_ctrl;
  localparam int TD = 4;
  localparam int ST = 2;
  localparam logic [15:0] E0 = 16'hA5C3;
  localparam logic [15:0] E1 = 16'h3C96;
  localparam logic [15:0] ES = 16'hF00F;
  localparam int SWEEP_CYC = 16 * (ST + 1) + 15 * TD;

  logic       clk = 1'b0;
  logic       rst, start, abort, mode, step_btn;
  logic       dut_led0, dut_led1, dut_seg_a;
  logic [3:0] sw_out, rd_addr;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [2:0] rd_data;

  logic [2:0] flt [16];
  logic [2:0] exp_log [16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sw_sweep_ctrl #(.TICK_DIV(TD), .SETTLE(ST), .EXP_LED0(E0), .EXP_LED1(E1), .EXP_SEGA(ES)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .step_btn(step_btn),
    .dut_led0(dut_led0), .dut_led1(dut_led1), .dut_seg_a(dut_seg_a),
    .sw_out(sw_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // modelled unit under test: truth table with optional per-code fault mask
  assign {dut_seg_a, dut_led1, dut_led0} = {ES[sw_out], E1[sw_out], E0[sw_out]} ^ flt[sw_out];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] truth(int c);
    return {ES[c], E1[c], E0[c]};
  endfunction

  function automatic int exp_err(int upto);
    int n = 0;
    for (int i = 0; i < upto; i++) if (flt[i] != 3'b000) n++;
    return n;
  endfunction

  task automatic model_sweep(int upto);
    for (int i = 0; i < upto; i++) exp_log[i] = truth(i) ^ flt[i];
  endtask

  task automatic clr_flt();
    for (int i = 0; i < 16; i++) flt[i] = 3'b000;
  endtask

  task automatic rand_flt(int nf);
    clr_flt();
    for (int k = 0; k < nf; k++) flt[$urandom_range(0, 15)] = 3'($urandom_range(1, 7));
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic check_log(string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s log[%0d]", tag, i), 32'(rd_data), 32'(exp_log[i]));
    end
    cyc(1);
  endtask

  task automatic wait_done(input int poke, output int n, output bit seq_ok);
    int last;
    bit ok;
    last = 0; ok = 1'b1; n = 0;
    while (done !== 1'b1 && n < 2000) begin
      cyc(1);
      n++;
      start = (n == poke);
      if (int'(sw_out) != last) begin
        if (int'(sw_out) != last + 1) ok = 1'b0;
        last = int'(sw_out);
      end
    end
    start = 1'b0;
    seq_ok = ok && (last == 15);
  endtask

  task automatic auto_sweep(string tag, int poke);
    int n;
    bit ok;
    do_start();
    chk({tag, " busy after start"}, 32'(busy), 1);
    chk({tag, " err cleared"}, 32'(err_cnt), 0);
    wait_done(poke, n, ok);
    model_sweep(16);
    chk({tag, " done edge"}, n, SWEEP_CYC);
    chk({tag, " sw_out sequence"}, 32'(ok), 1);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " busy low"}, 32'(busy), 0);
    chk({tag, " err_cnt"}, 32'(err_cnt), exp_err(16));
    chk({tag, " pass"}, 32'(pass), 32'(exp_err(16) == 0));
    check_log(tag);
  endtask

  initial begin
    int g;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; step_btn = 1'b0; rd_addr = '0;
    clr_flt();
    for (int i = 0; i < 16; i++) exp_log[i] = 3'b000;
    cyc(2);
    rst = 1'b0;

    // reset state
    chk("rst sw_out", 32'(sw_out), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst pass", 32'(pass), 0);
    chk("rst err_cnt", 32'(err_cnt), 0);
    check_log("rst");

    // clean auto sweep
    auto_sweep("clean", -1);

    // code 9 led1 fault, plus a start pulse mid-sweep that must be ignored
    clr_flt();
    flt[9] = 3'b010;
    auto_sweep("fault9", int'($urandom_range(10, 90)));

    // restart from DONE reproduces the same log and error count
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart done low", 32'(done), 0);
    chk("restart sw_out", 32'(sw_out), 0);
    cyc(1);
    g = 0;
    while (done !== 1'b1 && g < 2000) begin cyc(1); g++; end
    chk("restart err_cnt", 32'(err_cnt), 1);
    chk("restart pass", 32'(pass), 0);
    check_log("restart");

    // random fault patterns
    for (int r = 0; r < 3; r++) begin
      rand_flt(int'($urandom_range(1, 6)));
      auto_sweep($sformatf("rand%0d", r), -1);
    end

    // abort at code 7 with start in the same cycle
    rand_flt(int'($urandom_range(2, 6)));
    do_start();
    g = 0;
    while (sw_out != 4'd7 && g < 500) begin cyc(1); g++; end
    chk("reach code 7", 32'(sw_out), 7);
    abort = 1'b1; start = 1'b1;
    cyc(1);
    abort = 1'b0; start = 1'b0;
    chk("abort sw_out", 32'(sw_out), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort err kept", 32'(err_cnt), exp_err(7));
    cyc(5);
    chk("abort stays idle", 32'(busy), 0);
    model_sweep(7);
    check_log("abort");
    auto_sweep("after abort", -1);

    // manual mode
    rand_flt(int'($urandom_range(1, 5)));
    mode = 1'b1;
    do_start();
    cyc(ST + 1);
    for (int k = 1; k < 16; k++) begin
      cyc(int'($urandom_range(0, 5)));
      chk($sformatf("manual hold code %0d", k - 1), 32'(sw_out), 32'(k - 1));
      step_btn = 1'b1;
      cyc(1);
      chk($sformatf("manual step %0d", k), 32'(sw_out), 32'(k));
      if (k == 4) begin
        cyc(19);
        step_btn = 1'b0;
        chk("held button one step", 32'(sw_out), 4);
        cyc(ST + 2);
      end else if (k == 5) begin
        step_btn = 1'b0;
        cyc(1);
        step_btn = 1'b1;
        cyc(1);
        step_btn = 1'b0;
        cyc(8);
        chk("settle pulse ignored", 32'(sw_out), 5);
      end else begin
        step_btn = 1'b0;
        cyc(ST + 2);
      end
    end
    model_sweep(16);
    chk("manual done", 32'(done), 1);
    chk("manual err_cnt", 32'(err_cnt), exp_err(16));
    chk("manual pass", 32'(pass), 32'(exp_err(16) == 0));
    check_log("manual");
    mode = 1'b0;

    // asynchronous reset during WAIT_STEP of code 5
    clr_flt();
    flt[2] = 3'b101;
    do_start();
    g = 0;
    while (sw_out != 4'd5 && g < 500) begin cyc(1); g++; end
    repeat (ST + 1) @(posedge clk);
    #3;
    chk("pre-reset err_cnt", 32'(err_cnt), 1);
    chk("pre-reset busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async rst sw_out", 32'(sw_out), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst err_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 16; i++) exp_log[i] = 3'b000;
    check_log("async rst");
    rst = 1'b0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_sweep_ctrl.md
# sw_sweep_ctrl

Sequencer for the lab 4 switch-driven combinational unit (inputs sw0..sw3, outputs led0, led1, segment_a). It replaces manual switch toggling: it drives the unit's four inputs through all 16 codes, waits for outputs to settle, captures {segment_a, led1, led0} per code into a 16-entry log and checks them against expected truth-table masks. Stepping is either automatic from an internal prescaler or manual from a push-button edge. It sits between the board buttons/LEDs and the unit under test.

## Interface
- TICK_DIV, 50_000_000: auto-mode dwell per code, in clk cycles (≥1).
- SETTLE, 2: settle cycles after a code is applied, before capture (≥1).
- EXP_LED0, 16'h0000: expected led0; bit i is the value for code i.
- EXP_LED1, 16'h0000: expected led1, same encoding.
- EXP_SEGA, 16'h0000: expected segment_a, same encoding.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep from code 0.
- abort  in  1  level; returns to IDLE. Priority over start.
- mode  in  1  0 = auto step (prescaler), 1 = manual step (step_btn).
- step_btn  in  1  already synchronized/debounced button level.
- dut_led0, dut_led1, dut_seg_a  in  1 each  unit outputs.
- sw_out  out  4  drives {sw3,sw2,sw1,sw0} of the unit.
- busy  out  1  high in SETTLE/CAPTURE/WAIT_STEP.
- done  out  1  high in DONE.
- pass  out  1  done & (err_cnt == 0).
- err_cnt  out  5  count of codes with any captured bit ≠ expected (0..16).
- rd_addr  in  4  log read address.
- rd_data  out  3  combinational {seg_a, led1, led0} of log[rd_addr].

## Operation
- States: IDLE, SETTLE, CAPTURE, WAIT_STEP, DONE.
- IDLE: sw_out=0, busy=0, done=0. start → SETTLE with code=0, err_cnt=0, settle counter=SETTLE.
- SETTLE: sw_out=code; counter decrements every cycle; after exactly SETTLE cycles → CAPTURE.
- CAPTURE (1 cycle): log[code] ← {dut_seg_a, dut_led1, dut_led0}; err_cnt += 1 if any bit differs from EXP_*[code]. code==15 → DONE, else → WAIT_STEP.
- WAIT_STEP: auto: prescaler cleared on entry, leaves after TICK_DIV cycles. Manual: leaves on the cycle a step_btn rising edge is seen. Exit: code+1, → SETTLE.
- DONE: done=1, sw_out holds 15, err_cnt and log frozen. start → new sweep (done drops, err_cnt cleared).
- Edge detector: prev_btn registered every cycle in all states. Rising edge = step_btn & ~prev_btn. Edges outside WAIT_STEP are discarded, not queued. A held button gives one step only.
- start while busy: ignored. abort in any state → IDLE next edge, sw_out=0, err_cnt kept, log kept.
- mode is sampled only in WAIT_STEP. A change mid-sweep takes effect at the next WAIT_STEP cycle; the prescaler keeps counting.
- code has no wrap: the sweep always ends at 15.

## Timing
- Reset: state IDLE, sw_out=0, busy=0, done=0, pass=0, err_cnt=0, log all zero, prev_btn=0, prescaler=0.
- The start edge enters SETTLE; busy is high the cycle after start is sampled.
- Per-code cost in auto mode: SETTLE + 1 + TICK_DIV cycles. The last code has no WAIT_STEP.
- Full auto sweep: done rises 16·(SETTLE+1) + 15·TICK_DIV edges after the start edge (108 for SETTLE=2, TICK_DIV=4).
- Manual: the next code appears on sw_out 1 cycle after the edge that sees the button rise. Capture follows SETTLE+1 cycles later.
- rd_data is purely combinational from the log. A write in CAPTURE is visible at rd_data the next cycle.

## Test plan
- Reset mid-sweep: assert rst during WAIT_STEP of code 5 → sw_out=0, busy=0, err_cnt=0, rd_data=0 for all addresses, immediately (asynchronous).
- Auto sweep, matching model (TICK_DIV=4, SETTLE=2, unit modeled with EXP_* = its truth table) → sw_out steps 0..15, done at edge 108 after start, err_cnt=0, pass=1, rd_data[i] equals the model for all i.
- Fault injection: force dut_led1 inverted only for code 9 → err_cnt=1, pass=0, log[9] bit1 inverted, all other entries correct.
- Manual mode: hold step_btn high for 20 cycles → exactly one step, 3→4. A pulse during SETTLE → no step. Sweep completes after 15 distinct pulses.
- Abort during code 7 with start asserted in the same cycle → IDLE, sw_out=0, log[0..6] kept, log[7..15] unchanged. A later start sweeps from 0 and clears err_cnt.
- Restart from DONE: start → done=0 next cycle, sw_out=0, and a second full sweep reproduces identical log and err_cnt.
